// File: rtl/kmeans_pkg.sv
// Shared widths, latency, FSM states and seed helpers for the k-means assignment block.
// Build option KMEANS_EUCLID_EN selects squared-Euclidean distance (L=3) over Manhattan (L=2).
package kmeans_pkg;
    localparam int X_W        = 11;
    localparam int Y_W        = 10;
    localparam int DIST_MAN_W = 12;
    localparam int DIST_EUC_W = 23;
`ifdef KMEANS_EUCLID_EN
    localparam int DIST_W = DIST_EUC_W;
    localparam int LAT    = 3;
`else
    localparam int DIST_W = DIST_MAN_W;
    localparam int LAT    = 2;
`endif

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        WAIT_CENT = 2'd1,
        ARM       = 2'd2
    } state_t;

    // Seeds spread the clusters evenly across the width on the centre row.
    function automatic logic [X_W-1:0] seed_x(input int i, input int k, input int h);
        int v;
        v = (2 * i + 1) * h / (2 * k);
        return v[X_W-1:0];
    endfunction

    function automatic logic [Y_W-1:0] seed_y(input int v_active);
        int v;
        v = v_active / 2;
        return v[Y_W-1:0];
    endfunction
endpackage

// File: rtl/kmeans_argmin.sv
// Combinational K-way minimum over enabled distances; lowest index wins ties.
module kmeans_argmin
    import kmeans_pkg::*;
#(
    parameter  int K   = 4,
    parameter  int DW  = DIST_W,
    localparam int IDW = $clog2(K)
) (
    input  logic [K*DW-1:0] i_dist,
    input  logic [K-1:0]    i_en,
    output logic [IDW-1:0]  o_id,
    output logic [DW-1:0]   o_min
);
    logic w_found;

    // Strict less-than keeps the earlier index on equal distances.
    always_comb begin
        o_id    = '0;
        o_min   = '0;
        w_found = 1'b0;
        for (int i = 0; i < K; i++) begin
            if (i_en[i] && (!w_found || (i_dist[i*DW +: DW] < o_min))) begin
                o_min   = i_dist[i*DW +: DW];
                o_id    = IDW'(i);
                w_found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/kmeans_assign.sv
// Nearest-centroid classifier for masked pixels, with frame FSM and centroid latch.
// Define KMEANS_EUCLID_EN for squared-Euclidean distance with one extra pipeline stage.
module kmeans_assign
    import kmeans_pkg::*;
#(
    parameter  int K        = 4,
    parameter  int H_ACTIVE = 1280,
    parameter  int V_ACTIVE = 720,
    localparam int IDW      = $clog2(K)
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [X_W-1:0]   x_in,
    input  logic [Y_W-1:0]   y_in,
    input  logic             valid_in,
    input  logic             frame_done_in,
    input  logic [K*X_W-1:0] centroid_x_in,
    input  logic [K*Y_W-1:0] centroid_y_in,
    input  logic [K-1:0]     centroid_valid_in,
    input  logic             load_in,
    output logic [X_W-1:0]   x_out,
    output logic [Y_W-1:0]   y_out,
    output logic [IDW-1:0]   cluster_id_out,
    output logic             valid_out,
    output logic             tabulate_out,
    output logic [7:0]       iter_out,
    output logic             waiting_out
);
    state_t           r_state, w_state_nxt;
    logic             w_tab_nxt;
    logic [LAT-1:0]   r_fd_sr;
    logic [X_W-1:0]   r_cx [K];
    logic [Y_W-1:0]   r_cy [K];
    logic [K-1:0]     r_en;
    logic             w_vld_in;
    logic [X_W-1:0]   w_x_s1;
    logic [Y_W-1:0]   w_y_s1;
    logic             w_vld_s1;
    logic [K-1:0]     w_en_s1;
    logic [X_W-1:0]   r_x_p1;
    logic [Y_W-1:0]   r_y_p1;
    logic             r_vld_p1;
    logic [K-1:0]     r_en_p1;
    logic [K*DIST_W-1:0] w_dist_p1;
    logic [IDW-1:0]   w_id_p1;
    logic [DIST_W-1:0] w_dmin_unused;

    assign w_vld_in = valid_in && (r_state == RUN);

    // An all-invalid result set keeps the old positions but re-enables every cluster.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < K; i++) begin
                r_cx[i] <= seed_x(i, K, H_ACTIVE);
                r_cy[i] <= seed_y(V_ACTIVE);
            end
            r_en <= '1;
        end else if (load_in) begin
            if (centroid_valid_in == '0) begin
                r_en <= '1;
            end else begin
                r_en <= centroid_valid_in;
                for (int i = 0; i < K; i++) begin
                    if (centroid_valid_in[i]) begin
                        r_cx[i] <= centroid_x_in[i*X_W +: X_W];
                        r_cy[i] <= centroid_y_in[i*Y_W +: Y_W];
                    end
                end
            end
        end
    end

`ifdef KMEANS_EUCLID_EN
    logic [X_W-1:0] r_x_p0;
    logic [Y_W-1:0] r_y_p0;
    logic [K-1:0]   r_en_p0;
    logic           r_vld_p0;

    // Stage p0: squares registered, side-band follows.
    always_ff @(posedge clk_in) begin
        r_x_p0  <= x_in;
        r_y_p0  <= y_in;
        r_en_p0 <= r_en;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_vld_p0 <= 1'b0;
        else           r_vld_p0 <= w_vld_in;
    end

    assign w_x_s1   = r_x_p0;
    assign w_y_s1   = r_y_p0;
    assign w_vld_s1 = r_vld_p0;
    assign w_en_s1  = r_en_p0;
`else
    assign w_x_s1   = x_in;
    assign w_y_s1   = y_in;
    assign w_vld_s1 = w_vld_in;
    assign w_en_s1  = r_en;
`endif

    for (genvar g = 0; g < K; g++) begin : g_dist
        logic [X_W-1:0]    w_dx;
        logic [Y_W-1:0]    w_dy;
        logic [DIST_W-1:0] r_dist_p1;

        assign w_dx = (x_in >= r_cx[g]) ? (x_in - r_cx[g]) : (r_cx[g] - x_in);
        assign w_dy = (y_in >= r_cy[g]) ? (y_in - r_cy[g]) : (r_cy[g] - y_in);
`ifdef KMEANS_EUCLID_EN
        logic [2*X_W-1:0] r_sqx_p0;
        logic [2*Y_W-1:0] r_sqy_p0;

        always_ff @(posedge clk_in) begin
            r_sqx_p0  <= (2*X_W)'(w_dx) * (2*X_W)'(w_dx);
            r_sqy_p0  <= (2*Y_W)'(w_dy) * (2*Y_W)'(w_dy);
            r_dist_p1 <= DIST_W'(r_sqx_p0) + DIST_W'(r_sqy_p0);
        end
`else
        always_ff @(posedge clk_in) begin
            r_dist_p1 <= DIST_W'(w_dx) + DIST_W'(w_dy);
        end
`endif
        assign w_dist_p1[g*DIST_W +: DIST_W] = r_dist_p1;
    end

    // Stage p1: distances registered; the enable mask travels with them.
    always_ff @(posedge clk_in) begin
        r_x_p1  <= w_x_s1;
        r_y_p1  <= w_y_s1;
        r_en_p1 <= w_en_s1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_vld_p1 <= 1'b0;
        else           r_vld_p1 <= w_vld_s1;
    end

    kmeans_argmin #(.K(K), .DW(DIST_W)) u_argmin (
        .i_dist (w_dist_p1),
        .i_en   (r_en_p1),
        .o_id   (w_id_p1),
        .o_min  (w_dmin_unused)
    );

    // Stage p2: classified pixel out.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            x_out          <= '0;
            y_out          <= '0;
            cluster_id_out <= '0;
            valid_out      <= 1'b0;
        end else begin
            x_out          <= r_x_p1;
            y_out          <= r_y_p1;
            cluster_id_out <= w_id_p1;
            valid_out      <= r_vld_p1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tab_nxt   = 1'b0;
        case (r_state)
            RUN: begin
                if (r_fd_sr[LAT-1]) begin
                    w_state_nxt = WAIT_CENT;
                    w_tab_nxt   = 1'b1;
                end
            end
            WAIT_CENT: if (load_in)       w_state_nxt = ARM;
            ARM:       if (frame_done_in) w_state_nxt = RUN;
            default:                      w_state_nxt = RUN;
        endcase
    end

    // Frame-done only enters the delay line in RUN, so ARM's closing pulse never tabulates.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= RUN;
            r_fd_sr      <= '0;
            tabulate_out <= 1'b0;
            iter_out     <= '0;
            waiting_out  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_fd_sr      <= {r_fd_sr[LAT-2:0], frame_done_in && (r_state == RUN)};
            tabulate_out <= w_tab_nxt;
            waiting_out  <= (w_state_nxt != RUN);
            if (w_tab_nxt) iter_out <= iter_out + 8'd1;
        end
    end
endmodule

// File: tb/tb_kmeans_assign.sv
// Scoreboard bench for kmeans_assign: directed pixels, centroid loads, frame FSM and reset.
`timescale 1ns/1ps
module tb_kmeans_assign;
    import kmeans_pkg::*;
    localparam int K = 4;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [1:0]     id;
    } exp_t;

    logic             clk_in = 1'b0;
    logic             rst_n_in = 1'b0;
    logic [X_W-1:0]   x_in;
    logic [Y_W-1:0]   y_in;
    logic             valid_in;
    logic             frame_done_in;
    logic [K*X_W-1:0] centroid_x_in;
    logic [K*Y_W-1:0] centroid_y_in;
    logic [K-1:0]     centroid_valid_in;
    logic             load_in;
    logic [X_W-1:0]   x_out;
    logic [Y_W-1:0]   y_out;
    logic [1:0]       cluster_id_out;
    logic             valid_out;
    logic             tabulate_out;
    logic [7:0]       iter_out;
    logic             waiting_out;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_mis = 0;
    int   n_tab = 0;

    kmeans_assign #(.K(K), .H_ACTIVE(1280), .V_ACTIVE(720)) dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .x_in              (x_in),
        .y_in              (y_in),
        .valid_in          (valid_in),
        .frame_done_in     (frame_done_in),
        .centroid_x_in     (centroid_x_in),
        .centroid_y_in     (centroid_y_in),
        .centroid_valid_in (centroid_valid_in),
        .load_in           (load_in),
        .x_out             (x_out),
        .y_out             (y_out),
        .cluster_id_out    (cluster_id_out),
        .valid_out         (valid_out),
        .tabulate_out      (tabulate_out),
        .iter_out          (iter_out),
        .waiting_out       (waiting_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (tabulate_out) begin
                n_tab++;
                chk("tab_not_with_valid", int'(valid_out), 0);
            end
            if (valid_out) begin
                chk("expected_pending", int'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("x_out", int'(x_out), int'(e.x));
                    chk("y_out", int'(y_out), int'(e.y));
                    chk("cluster_id", int'(cluster_id_out), int'(e.id));
                end
            end
        end
    endtask

    task automatic push_exp(input int x, input int y, input int id);
        exp_t e;
        e.x = X_W'(x);
        e.y = Y_W'(y);
        e.id = 2'(id);
        sb_q.push_back(e);
    endtask

    task automatic pix(input int x, input int y, input int id, input bit push, input bit fd);
        x_in          = X_W'(x);
        y_in          = Y_W'(y);
        valid_in      = 1'b1;
        frame_done_in = fd;
        if (push) push_exp(x, y, id);
        @(posedge clk_in); #1;
        valid_in      = 1'b0;
        frame_done_in = 1'b0;
    endtask

    task automatic ld(input logic [K-1:0] v, input logic [K*X_W-1:0] cx,
                      input logic [K*Y_W-1:0] cy, input bit fd);
        centroid_valid_in = v;
        centroid_x_in     = cx;
        centroid_y_in     = cy;
        load_in           = 1'b1;
        frame_done_in     = fd;
        @(posedge clk_in); #1;
        load_in       = 1'b0;
        frame_done_in = 1'b0;
        valid_in      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_in); #1;
        end
    endtask

    initial begin
        bit seen;
        x_in = '0; y_in = '0; valid_in = 1'b0; frame_done_in = 1'b0;
        centroid_x_in = '0; centroid_y_in = '0; centroid_valid_in = '0; load_in = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_valid_out", int'(valid_out), 0);
        chk("rst_tabulate", int'(tabulate_out), 0);
        chk("rst_iter", int'(iter_out), 0);
        chk("rst_waiting", int'(waiting_out), 0);
        chk("rst_x_out", int'(x_out), 0);
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        idle(1);

        // Seeds 160/480/800/1120 @ 360
        pix(170, 360, 0, 1, 0);
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk_in);
            chk("latency_valid", int'(valid_out), int'(i == LAT));
        end
        pix(1000, 100, 3, 1, 0);
        idle(LAT + 1);

        // Pixel in the load cycle still sees the seeds
        x_in = 11'd800; y_in = 10'd360; valid_in = 1'b1;
        push_exp(800, 360, 2);
        ld(4'b1111, {11'd900, 11'd500, 11'd100, 11'd100}, {10'd600, 10'd500, 10'd100, 10'd100}, 0);
        pix(100, 100, 0, 1, 0);
        pix(800, 360, 3, 1, 0);
        idle(LAT + 1);

        // Cluster 2 disabled, keeps (500,500)
        ld(4'b1011, {11'd1000, 11'd0, 11'd300, 11'd200}, {10'd600, 10'd0, 10'd300, 10'd200}, 0);
        pix(500, 500, 1, 1, 0);
        ld(4'b0000, '0, '0, 0);
        pix(500, 500, 2, 1, 0);
        pix(1000, 600, 3, 1, 0);
        pix(200, 200, 0, 1, 0);
        idle(LAT + 1);

        // Frame end coincident with last pixel
        pix(200, 200, 0, 1, 1);
        for (int i = 1; i <= LAT + 1; i++) begin
            @(negedge clk_in);
            chk("tab_timing", int'(tabulate_out), int'(i == LAT + 1));
        end
        chk("iter_after_frame1", int'(iter_out), 1);
        chk("waiting_after_frame1", int'(waiting_out), 1);
        @(negedge clk_in);
        chk("tab_one_cycle", int'(tabulate_out), 0);
        #1;

        // WAIT_CENT drops pixels and ignores frame_done
        for (int i = 0; i < 10; i++) pix(100 + 50 * i, 200 + 10 * i, 0, 0, (i == 4));
        ld(4'b1111, {11'd1000, 11'd500, 11'd300, 11'd200}, {10'd600, 10'd500, 10'd300, 10'd200}, 1);
        @(negedge clk_in);
        chk("waiting_in_arm", int'(waiting_out), 1);
        #1;
        for (int i = 0; i < 5; i++) pix(300 + i, 300, 0, 0, 0);
        ld(4'b1111, {11'd1000, 11'd500, 11'd300, 11'd200}, {10'd600, 10'd500, 10'd300, 10'd200}, 0);
        @(negedge clk_in);
        chk("arm_load_stays", int'(waiting_out), 1);
        #1;
        pix(300, 300, 0, 0, 1);
        @(negedge clk_in);
        chk("run_after_arm", int'(waiting_out), 0);
        chk("iter_held", int'(iter_out), 1);
        #1;
        idle(LAT + 3);
        chk("no_tab_in_wait_arm", n_tab, 1);

        // Second frame
        pix(300, 300, 1, 1, 0);
        pix(510, 490, 2, 1, 0);
        pix(1000, 600, 3, 1, 0);
        pix(205, 195, 0, 1, 1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk_in);
            if (tabulate_out) begin
                seen = 1'b1;
                chk("iter_after_frame2", int'(iter_out), 2);
            end
        end
        chk("tab_frame2_seen", int'(seen), 1);
        #1;
        ld(4'b1111, {11'd1000, 11'd500, 11'd300, 11'd200}, {10'd600, 10'd500, 10'd300, 10'd200}, 0);
        pix(0, 0, 0, 0, 1);

        // Reset with two pixels in flight
        pix(160, 360, 0, 0, 0);
        pix(480, 360, 1, 0, 0);
        rst_n_in = 1'b0;
        #1;
        chk("midrst_valid_out", int'(valid_out), 0);
        chk("midrst_iter", int'(iter_out), 0);
        chk("midrst_waiting", int'(waiting_out), 0);
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        pix(160, 360, 0, 1, 0);
        pix(480, 360, 1, 1, 0);
        pix(800, 360, 2, 1, 0);
        pix(1120, 360, 3, 1, 0);
        pix(700, 100, 2, 1, 0);
        idle(LAT + 2);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
